// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry, pixel/command types and the fill FSM
// state encoding for the rectangle-fill writer and its address generator.
package fb_pkg;

  localparam logic [31:0] FB_BASE    = 32'h0800_0000;
  localparam int          LINE_BYTES = 1280;
  localparam int          SCR_W      = 640;
  localparam int          SCR_H      = 480;

  typedef logic [15:0] fb_pixel_t;

  typedef struct packed {
    logic [9:0] x0;
    logic [8:0] y0;
    logic [9:0] w;
    logic [8:0] h;
    fb_pixel_t  color;
  } fb_rect_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ROW,
    S_ISSUE,
    S_HOLD,
    S_NEXTROW,
    S_DONE
  } fill_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: combinational pixel (x,y) -> framebuffer word byte address and
// lane mask. Two pixels per 32-bit word: even x in lanes [1:0], odd x in [3:2].
// Ports:
//   x, y   : pixel column / line (11-bit, unclipped coordinates allowed)
//   x_end  : last covered column of the current row (trims the final word)
//   addr   : word-aligned byte address
//   be     : byte enables for the word
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [10:0] x_end,
  output logic [31:0] addr,
  output logic [3:0]  be
);

  logic [31:0] row_off;
  logic [31:0] col_off;

  assign row_off = 32'(y) * 32'(LINE_BYTES);
  assign col_off = {20'd0, x[10:1], 2'b00};
  assign addr    = FB_BASE + row_off + col_off;

  // A word starting on an odd pixel only covers its upper lane; a word whose
  // even pixel is the row's last pixel only covers its lower lane.
  always_comb begin
    if (x[0])             be = 4'b1100;
    else if (x == x_end)  be = 4'b0011;
    else                  be = 4'b1111;
  end

endmodule

// File: rtl/fb_rect_fill.sv
// fb_rect_fill: Avalon-MM write master filling an axis-aligned rectangle of
// the 640x480 RGB444 framebuffer with a single colour, one word per beat.
// Optional clipping to the screen is enabled with macro FB_RECT_CLIP_EN.
// Ports:
//   clk, reset                : clock, async active-low reset
//   cmd_valid/cmd_ready       : command handshake
//   cmd_x0/y0/w/h/color       : rectangle and fill colour
//   busy, done                : command in flight / one-cycle completion pulse
//   avalon_master_*           : single-beat write master (no bursts)
module fb_rect_fill
  import fb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x0,
  input  logic [8:0]  cmd_y0,
  input  logic [9:0]  cmd_w,
  input  logic [8:0]  cmd_h,
  input  logic [15:0] cmd_color,
  output logic        busy,
  output logic        done,
  output logic        avalon_master_write,
  output logic [31:0] avalon_master_address,
  output logic [31:0] avalon_master_writedata,
  output logic [3:0]  avalon_master_byteenable,
  input  logic        avalon_master_waitrequest
);

  fill_state_t state, state_n;
  fb_rect_t    rect;
  logic [10:0] x_end, y_end, cur_x, cur_y;
  logic [10:0] x_end_c, y_end_c;
  logic        empty_c;
  logic        row_end_c;
  logic [31:0] ag_addr;
  logic [3:0]  ag_be;

  fb_addr_gen u_addr (
    .x     (cur_x),
    .y     (cur_y),
    .x_end (x_end),
    .addr  (ag_addr),
    .be    (ag_be)
  );

  // Rectangle extents; 11 bits so x0+w-1 never wraps.
  always_comb begin
    x_end_c = {1'b0, rect.x0} + {1'b0, rect.w} - 11'd1;
    y_end_c = {2'b0, rect.y0} + {2'b0, rect.h} - 11'd1;
    empty_c = (rect.w == '0) || (rect.h == '0);
`ifdef FB_RECT_CLIP_EN
    if (x_end_c > 11'(SCR_W - 1)) x_end_c = 11'(SCR_W - 1);
    if (y_end_c > 11'(SCR_H - 1)) y_end_c = 11'(SCR_H - 1);
    if (({1'b0, rect.x0} >= 11'(SCR_W)) || ({2'b0, rect.y0} >= 11'(SCR_H)))
      empty_c = 1'b1;
`endif
  end

  // The current beat covers up to the odd pixel of its word; if that pixel
  // reaches x_end the row is finished (also true for a trimmed 0011 word).
  assign row_end_c = ({cur_x[10:1], 1'b1} >= x_end);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (cmd_valid && cmd_ready) state_n = S_SETUP;
      S_SETUP:   state_n = empty_c ? S_DONE : S_ROW;
      S_ROW:     state_n = S_ISSUE;
      S_ISSUE:   state_n = S_HOLD;
      S_HOLD:    if (!avalon_master_waitrequest)
                   state_n = row_end_c ? S_NEXTROW : S_ISSUE;
      S_NEXTROW: state_n = (cur_y == y_end) ? S_DONE : S_ROW;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rect                     <= '0;
      x_end                    <= '0;
      y_end                    <= '0;
      cur_x                    <= '0;
      cur_y                    <= '0;
      cmd_ready                <= 1'b1;
      busy                     <= 1'b0;
      done                     <= 1'b0;
      avalon_master_write      <= 1'b0;
      avalon_master_address    <= '0;
      avalon_master_writedata  <= '0;
      avalon_master_byteenable <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: if (cmd_valid && cmd_ready) begin
          rect.x0    <= cmd_x0;
          rect.y0    <= cmd_y0;
          rect.w     <= cmd_w;
          rect.h     <= cmd_h;
          rect.color <= cmd_color;
          cmd_ready  <= 1'b0;
          busy       <= 1'b1;
        end
        S_SETUP: begin
          x_end <= x_end_c;
          y_end <= y_end_c;
          cur_y <= {2'b0, rect.y0};
        end
        S_ROW:   cur_x <= {1'b0, rect.x0};
        S_ISSUE: begin
          avalon_master_write      <= 1'b1;
          avalon_master_address    <= ag_addr;
          avalon_master_writedata  <= {rect.color, rect.color};
          avalon_master_byteenable <= ag_be;
        end
        S_HOLD: if (!avalon_master_waitrequest) begin
          avalon_master_write <= 1'b0;
          if (!row_end_c) cur_x <= {cur_x[10:1], 1'b0} + 11'd2;
        end
        S_NEXTROW: if (cur_y != y_end) cur_y <= cur_y + 11'd1;
        S_DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
